mem_arbiter: RTL and testbench

Arbitrates a single-port RAM between the instruction-fetch and data-access request streams of the CPU datapath. Instruction requests come from the fetch side; data requests come from the request unit. A three-state grant FSM holds the RAM for one requester until the RAM reports ACCESS. Data requests have priority, bounded by a starvation counter that guarantees instruction progress.

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/starve_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t      - 32-bit machine word
//   ramstate_t  - single-port RAM status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t - memory arbiter grant state (IDLE, GRANT_I, GRANT_D)
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of data grants taken over a waiting fetch.
//   CLK, nRST - clock, asynchronous active-low reset
//   inc       - count one (stops at LIMIT)
//   clr       - return to zero; wins over inc
//   cnt       - current count
//   sat       - cnt has reached LIMIT
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    assign sat = cnt == MAX;

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) cnt <= '0;
        else cnt <= clr ? '0 : (inc && !sat) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data access.
//   CLK, nRST                     - clock, asynchronous active-low reset
//   iREN, iaddr / iwait, iload    - instruction read request and completion
//   dREN, dWEN, daddr, dstore /
//   dwait, dload                  - data read/write request and completion
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate  - RAM command and response
//   memerr                        - one-cycle pulse after a grant aborted by ERROR
// Data requests win in IDLE unless a fetch has waited through STARVE_LIMIT
// consecutive data grants (STARVE_LIMIT = 0 disables the bound).
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_t    state, next_state;
    logic [CW-1:0] starve_cnt;
    logic          starve_sat, starving, dreq, grant_live, done, err, cnt_inc, cnt_clr;

    assign dreq     = dREN | dWEN;
    assign starving = (STARVE_LIMIT != 0) && iREN && starve_sat;

    // The granted requester still holding its enable; a withdrawn request
    // ends the grant without completing even if the RAM answers ACCESS.
    assign grant_live = (state == GRANT_I) ? iREN : (state == GRANT_D) ? dreq : 1'b0;
    assign done       = grant_live && ramstate == ACCESS;
    assign err        = grant_live && ramstate == ERROR;

    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = (dreq && !starving) ? GRANT_D : iREN ? GRANT_I : IDLE;
        else if (!grant_live || done || err) next_state = IDLE;
    end

    assign cnt_inc = state == IDLE && next_state == GRANT_D && iREN;
    assign cnt_clr = state == IDLE && (next_state == GRANT_I || !iREN);

    starve_counter #(.LIMIT(STARVE_LIMIT), .W(CW)) u_starve (
        .CLK (CLK),
        .nRST(nRST),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state  <= IDLE;
            memerr <= 1'b0;
        end else begin
            state  <= next_state;
            memerr <= err;
        end

    // RAM command depends only on state and the granted requester's inputs;
    // dWEN overrides dREN when both are raised.
    assign ramREN   = (state == GRANT_I) ? iREN : (state == GRANT_D) ? dREN & ~dWEN : 1'b0;
    assign ramWEN   = (state == GRANT_D) & dWEN;
    assign ramaddr  = (state == GRANT_I) ? iaddr : (state == GRANT_D) ? daddr : '0;
    assign ramstore = (state == GRANT_D) ? dstore : '0;

    assign iwait = !(state == GRANT_I && done);
    assign dwait = !(state == GRANT_D && done);
    assign iload = ramload;
    assign dload = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench for mem_arbiter (STARVE_LIMIT = 2).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam word_t IA = 32'h40, DA = 32'h100, DS = 32'hDEADBEEF;
    localparam int    NV = 32;

    typedef struct {
        logic       iren, dren, dwen;
        ramstate_t  rs;
        arb_state_t st;
        logic       iw, dw, rren, rwen, merr;
        int         cnt;
    } vec_t;

    logic      CLK, nRST, iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN, memerr;
    word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    vec_t      tv[NV];
    int        total = 0, bad = 0;

    mem_arbiter #(.STARVE_LIMIT(2)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iren, dren, dwen, input ramstate_t rs, input arb_state_t st,
                                input logic iw, dw, rren, rwen, merr, input int cnt);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.st = st;
        v.iw = iw; v.dw = dw; v.rren = rren; v.rwen = rwen; v.merr = merr; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        // single read, ACCESS on first grant cycle
        tv[0]  = mk(1,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        tv[1]  = mk(1,0,0,ACCESS,GRANT_I,0,1,1,0,0,0);
        tv[2]  = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        // write held through three BUSY cycles
        tv[3]  = mk(0,0,1,FREE,  IDLE,   1,1,0,0,0,0);
        tv[4]  = mk(0,0,1,BUSY,  GRANT_D,1,1,0,1,0,0);
        tv[5]  = mk(0,0,1,BUSY,  GRANT_D,1,1,0,1,0,0);
        tv[6]  = mk(0,0,1,BUSY,  GRANT_D,1,1,0,1,0,0);
        tv[7]  = mk(0,0,1,ACCESS,GRANT_D,1,0,0,1,0,0);
        tv[8]  = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        // data read aborted by ERROR
        tv[9]  = mk(0,1,0,FREE,  IDLE,   1,1,0,0,0,0);
        tv[10] = mk(0,1,0,ERROR, GRANT_D,1,1,1,0,0,0);
        tv[11] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,1,0);
        tv[12] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        // fetch withdrawn while waiting; ACCESS that cycle must not complete it
        tv[13] = mk(1,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        tv[14] = mk(1,0,0,BUSY,  GRANT_I,1,1,1,0,0,0);
        tv[15] = mk(0,0,0,ACCESS,GRANT_I,1,1,0,0,0,0);
        tv[16] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        // dREN and dWEN together: write wins
        tv[17] = mk(0,1,1,FREE,  IDLE,   1,1,0,0,0,0);
        tv[18] = mk(0,1,1,ACCESS,GRANT_D,1,0,0,1,0,0);
        tv[19] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);
        // contention, limit 2: grants D, D, I, D, D
        tv[20] = mk(1,1,0,ACCESS,IDLE,   1,1,0,0,0,0);
        tv[21] = mk(1,1,0,ACCESS,GRANT_D,1,0,1,0,0,1);
        tv[22] = mk(1,1,0,ACCESS,IDLE,   1,1,0,0,0,1);
        tv[23] = mk(1,1,0,ACCESS,GRANT_D,1,0,1,0,0,2);
        tv[24] = mk(1,1,0,ACCESS,IDLE,   1,1,0,0,0,2);
        tv[25] = mk(1,1,0,ACCESS,GRANT_I,0,1,1,0,0,0);
        tv[26] = mk(1,1,0,ACCESS,IDLE,   1,1,0,0,0,0);
        tv[27] = mk(1,1,0,ACCESS,GRANT_D,1,0,1,0,0,1);
        tv[28] = mk(1,1,0,ACCESS,IDLE,   1,1,0,0,0,1);
        tv[29] = mk(1,1,0,ACCESS,GRANT_D,1,0,1,0,0,2);
        tv[30] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,2);
        tv[31] = mk(0,0,0,FREE,  IDLE,   1,1,0,0,0,0);

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS; ramload = '0; ramstate = FREE;
        #1;
        chk("rst_state", -1, 32'(u_dut.state), 32'(IDLE));
        chk("rst_cnt",   -1, 32'(u_dut.starve_cnt), 0);
        chk("rst_ren",   -1, 32'(ramREN), 0);
        chk("rst_wen",   -1, 32'(ramWEN), 0);
        chk("rst_addr",  -1, ramaddr, 0);
        chk("rst_store", -1, ramstore, 0);
        chk("rst_iwait", -1, 32'(iwait), 1);
        chk("rst_dwait", -1, 32'(dwait), 1);
        chk("rst_memerr",-1, 32'(memerr), 0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            word_t xa, xs, ld;
            @(negedge CLK);
            iREN = tv[i].iren; dREN = tv[i].dren; dWEN = tv[i].dwen; ramstate = tv[i].rs;
            ld = 32'h2108000A ^ (32'(i - 1) << 12);
            ramload = ld;
            if (tv[i].dren && tv[i].dwen)
                $display("note: row %0d raises dREN and dWEN together (protocol violation, write expected to win)", i);
            xa = (tv[i].st == GRANT_I) ? IA : (tv[i].st == GRANT_D) ? DA : 32'h0;
            xs = (tv[i].st == GRANT_D) ? DS : 32'h0;
            #1;
            chk("state",    i, 32'(u_dut.state), 32'(tv[i].st));
            chk("starve",   i, 32'(u_dut.starve_cnt), 32'(tv[i].cnt));
            chk("iwait",    i, 32'(iwait), 32'(tv[i].iw));
            chk("dwait",    i, 32'(dwait), 32'(tv[i].dw));
            chk("one_wait", i, 32'(iwait | dwait), 1);
            chk("ramREN",   i, 32'(ramREN), 32'(tv[i].rren));
            chk("ramWEN",   i, 32'(ramWEN), 32'(tv[i].rwen));
            chk("ramaddr",  i, ramaddr, xa);
            chk("ramstore", i, ramstore, xs);
            chk("memerr",   i, 32'(memerr), 32'(tv[i].merr));
            chk("iload",    i, iload, ld);
            chk("dload",    i, dload, ld);
        end

        // reset asserted in the middle of a data write grant
        @(negedge CLK);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; ramstate = FREE;
        #1 chk("mid_idle", 100, 32'(u_dut.state), 32'(IDLE));
        @(negedge CLK);
        ramstate = BUSY;
        #1;
        chk("mid_grant", 101, 32'(u_dut.state), 32'(GRANT_D));
        chk("mid_wen",   101, 32'(ramWEN), 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_wen",   102, 32'(ramWEN), 0);
        chk("arst_ren",   102, 32'(ramREN), 0);
        chk("arst_state", 102, 32'(u_dut.state), 32'(IDLE));
        chk("arst_dwait", 102, 32'(dwait), 1);
        @(negedge CLK);
        dWEN = 1'b0; ramstate = FREE; nRST = 1'b1;
        #1;
        chk("rel_state",  103, 32'(u_dut.state), 32'(IDLE));
        chk("rel_memerr", 103, 32'(memerr), 0);
        chk("rel_addr",   103, ramaddr, 0);
        @(negedge CLK);
        #1 chk("rel_hold", 104, 32'(u_dut.state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
